// File: rtl/stopwatch_display_pkg.sv
// Shared constants for the stopwatch display: common-anode segment patterns
// (seg[6:0] = g..a, active-low) and the digit index type.
package stopwatch_display_pkg;

    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_E = 7'b0000110;

    // Full 8-bit blank (all segments and dp dark).
    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_BLANK  = 4'b1111;

    // Digit index; the value equals the anode bit it selects.
    typedef enum logic [1:0] {
        DIG_MSEC_L = 2'd0,
        DIG_MSEC_H = 2'd1,
        DIG_SEC_L  = 2'd2,
        DIG_SEC_H  = 2'd3
    } digit_idx_t;

endpackage

// File: rtl/stopwatch_display_bcd_to_seg.sv
// Combinational BCD to 7-segment decoder; any value above 9 shows "E".
module bcd_to_seg
    import stopwatch_display_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    // Pattern lookup; out-of-range codes fall through to the error glyph.
    always_comb begin
        seg = SEG_E;
        case (bcd)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_E;
        endcase
    end

endmodule

// File: rtl/stopwatch_display.sv
// Four-digit multiplexed stopwatch display driver with per-frame shadowing,
// leading-zero blanking, overflow blink and registered an/seg outputs.
module stopwatch_display
    import stopwatch_display_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 1,
    parameter int unsigned BLINK_HALF = 250
) (
    input  logic       clk_1khz,
    input  logic       rst_n,
    input  logic       disp_en,
    input  logic [2:0] time_sec_h,
    input  logic [3:0] time_sec_l,
    input  logic [3:0] time_msec_h,
    input  logic [3:0] time_msec_l,
    input  logic       time_out,
    output logic [3:0] an,
    output logic [7:0] seg
);

    logic [7:0] div_r;
    digit_idx_t idx_r;
    logic       step_s;
    logic       frame_wrap_s;

    logic [2:0] sh_sec_h_r;
    logic [3:0] sh_sec_l_r;
    logic [3:0] sh_msec_h_r;
    logic [3:0] sh_msec_l_r;
    logic       sh_to_r;
    logic       to_next_s;

    logic [9:0] blink_cnt_r;
    logic       blink_on_r;

    logic [3:0] digit_s;
    logic [3:0] an_sel_s;
    logic       dp_s;
    logic       lz_s;
    logic [6:0] seg7_s;
    logic [3:0] an_next_s;
    logic [7:0] seg_next_s;

    assign step_s       = (div_r == 8'(SCAN_DIV - 1));
    assign frame_wrap_s = step_s && (idx_r == DIG_SEC_H);
    // The overflow flag seen after this edge; a wrap coinciding with a rise
    // takes the new value.
    assign to_next_s    = frame_wrap_s ? time_out : sh_to_r;

    // Scan divider and digit index.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            div_r <= 8'd0;
            idx_r <= DIG_MSEC_L;
        end else if (step_s) begin
            div_r <= 8'd0;
            idx_r <= digit_idx_t'(idx_r + 2'd1);
        end else begin
            div_r <= div_r + 8'd1;
        end
    end

    // Shadow capture at the frame boundary so a frame never tears.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            sh_sec_h_r  <= 3'd0;
            sh_sec_l_r  <= 4'd0;
            sh_msec_h_r <= 4'd0;
            sh_msec_l_r <= 4'd0;
            sh_to_r     <= 1'b0;
        end else if (frame_wrap_s) begin
            sh_sec_h_r  <= time_sec_h;
            sh_sec_l_r  <= time_sec_l;
            sh_msec_h_r <= time_msec_h;
            sh_msec_l_r <= time_msec_l;
            sh_to_r     <= time_out;
        end else begin
            sh_sec_h_r  <= sh_sec_h_r;
            sh_sec_l_r  <= sh_sec_l_r;
            sh_msec_h_r <= sh_msec_h_r;
            sh_msec_l_r <= sh_msec_l_r;
            sh_to_r     <= sh_to_r;
        end
    end

    // Blink timer: runs only while the captured overflow flag stays high,
    // otherwise parked at 0 with the display on.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_r <= 10'd0;
            blink_on_r  <= 1'b1;
        end else if (!sh_to_r || !to_next_s) begin
            blink_cnt_r <= 10'd0;
            blink_on_r  <= 1'b1;
        end else if (blink_cnt_r == 10'(BLINK_HALF - 1)) begin
            blink_cnt_r <= 10'd0;
            blink_on_r  <= ~blink_on_r;
        end else begin
            blink_cnt_r <= blink_cnt_r + 10'd1;
            blink_on_r  <= blink_on_r;
        end
    end

    // Select the shadow digit, anode pattern, dp and leading-zero flag.
    always_comb begin
        digit_s  = 4'd0;
        an_sel_s = AN_BLANK;
        dp_s     = 1'b1;
        lz_s     = 1'b0;
        case (idx_r)
            DIG_MSEC_L: begin
                digit_s  = sh_msec_l_r;
                an_sel_s = 4'b1110;
            end
            DIG_MSEC_H: begin
                digit_s  = sh_msec_h_r;
                an_sel_s = 4'b1101;
            end
            DIG_SEC_L: begin
                digit_s  = sh_sec_l_r;
                an_sel_s = 4'b1011;
                dp_s     = 1'b0;
            end
            DIG_SEC_H: begin
                // Tens of seconds above 5 is invalid; force the error glyph.
                digit_s  = (sh_sec_h_r > 3'd5) ? 4'hF : {1'b0, sh_sec_h_r};
                an_sel_s = 4'b0111;
                lz_s     = (sh_sec_h_r == 3'd0);
            end
            default: begin
                digit_s  = 4'd0;
                an_sel_s = AN_BLANK;
            end
        endcase
    end

    bcd_to_seg u_bcd_to_seg (
        .bcd (digit_s),
        .seg (seg7_s)
    );

    // Blank precedence: disable, then blink-off, then leading zero.
    always_comb begin
        an_next_s  = AN_BLANK;
        seg_next_s = SEG_BLANK;
        if (!disp_en) begin
            an_next_s  = AN_BLANK;
            seg_next_s = SEG_BLANK;
        end else if (!blink_on_r) begin
            an_next_s  = AN_BLANK;
            seg_next_s = SEG_BLANK;
        end else if (lz_s) begin
            an_next_s  = AN_BLANK;
            seg_next_s = SEG_BLANK;
        end else begin
            an_next_s  = an_sel_s;
            seg_next_s = {dp_s, seg7_s};
        end
    end

    // Registered display outputs; reset blanks them without a clock.
    always_ff @(posedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            an  <= AN_BLANK;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next_s;
            seg <= seg_next_s;
        end
    end

endmodule

// File: tb/tb_stopwatch_display.sv
// Scoreboard bench: a frame-level reference model pushes the expected an/seg
// for every clock into a queue; a separate monitor pops and compares.
module tb_stopwatch_display;

    localparam int SD = 2;
    localparam int BH = 4;

    logic       clk_1khz = 1'b0;
    logic       rst_n = 1'b0;
    logic       disp_en = 1'b0;
    logic [2:0] time_sec_h = 3'd0;
    logic [3:0] time_sec_l = 4'd0;
    logic [3:0] time_msec_h = 4'd0;
    logic [3:0] time_msec_l = 4'd0;
    logic       time_out = 1'b0;
    logic [3:0] an;
    logic [7:0] seg;

    typedef struct {
        logic [3:0] an;
        logic [7:0] seg;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   passed = 0;

    stopwatch_display #(.SCAN_DIV(SD), .BLINK_HALF(BH)) dut (
        .clk_1khz    (clk_1khz),
        .rst_n       (rst_n),
        .disp_en     (disp_en),
        .time_sec_h  (time_sec_h),
        .time_sec_l  (time_sec_l),
        .time_msec_h (time_msec_h),
        .time_msec_l (time_msec_l),
        .time_out    (time_out),
        .an          (an),
        .seg         (seg)
    );

    always #5 clk_1khz = ~clk_1khz;

    function automatic logic [6:0] ref_pat(input int v);
        case (v)
            0: ref_pat = 7'h40;
            1: ref_pat = 7'h79;
            2: ref_pat = 7'h24;
            3: ref_pat = 7'h30;
            4: ref_pat = 7'h19;
            5: ref_pat = 7'h12;
            6: ref_pat = 7'h02;
            7: ref_pat = 7'h78;
            8: ref_pat = 7'h00;
            9: ref_pat = 7'h10;
            default: ref_pat = 7'h06;
        endcase
    endfunction

    // Reference model state: edges since reset, captured digits
    // (0 = msec_l .. 3 = sec_h), captured overflow and the edge it rose on.
    int   m;
    int   sh[4];
    bit   sh_to;
    int   cap_edge;
    int   ridx;
    bit   ron;
    bit   rvalid;
    exp_t e;

    // Reference model: predicts the output produced by this edge.
    always @(posedge clk_1khz) begin
        if (!rst_n) begin
            m = 0;
            sh = '{0, 0, 0, 0};
            sh_to = 1'b0;
            cap_edge = 0;
            q.delete();
        end else begin
            ridx = (m / SD) % 4;
            ron  = !sh_to || (((m - cap_edge) / BH) % 2 == 0);
            if (!disp_en || !ron || (ridx == 3 && sh[3] == 0)) begin
                e.an  = 4'hF;
                e.seg = 8'hFF;
            end else begin
                rvalid = (ridx == 3) ? (sh[3] <= 5) : (sh[ridx] <= 9);
                e.an = 4'hF;
                e.an[ridx] = 1'b0;
                e.seg = {(ridx == 2) ? 1'b0 : 1'b1, rvalid ? ref_pat(sh[ridx]) : 7'h06};
            end
            q.push_back(e);
            m = m + 1;
            if (m % (4 * SD) == 0) begin
                if (!sh_to && time_out) cap_edge = m;
                sh_to = time_out;
                sh[0] = int'(time_msec_l);
                sh[1] = int'(time_msec_h);
                sh[2] = int'(time_sec_l);
                sh[3] = int'(time_sec_h);
            end
        end
    end

    exp_t got;

    // Monitor: during reset the display must be dark (checked 1 time unit
    // after reset falls, with no clock); otherwise compare against the queue.
    always @(negedge clk_1khz or negedge rst_n) begin
        if (!rst_n) begin
            #1;
            checks = checks + 1;
            if (an !== 4'hF || seg !== 8'hFF)
                $display("FAIL rst_blank t=%0t got an=%b seg=%h want an=1111 seg=ff", $time, an, seg);
            else
                passed = passed + 1;
        end else if (q.size() > 0) begin
            got = q.pop_front();
            checks = checks + 1;
            if (an !== got.an || seg !== got.seg)
                $display("FAIL scan_out t=%0t got an=%b seg=%h want an=%b seg=%h",
                         $time, an, seg, got.an, got.seg);
            else
                passed = passed + 1;
        end
    end

    task automatic set_digits(input int sh_v, input int sl_v, input int mh_v, input int ml_v);
        time_sec_h  = 3'(sh_v);
        time_sec_l  = 4'(sl_v);
        time_msec_h = 4'(mh_v);
        time_msec_l = 4'(ml_v);
    endtask

    task automatic rand_digits();
        if ($urandom_range(0, 3) == 0)
            set_digits($urandom_range(0, 7), $urandom_range(0, 15),
                       $urandom_range(0, 15), $urandom_range(0, 15));
        else
            set_digits($urandom_range(0, 5), $urandom_range(0, 9),
                       $urandom_range(0, 9), $urandom_range(0, 9));
    endtask

    initial begin
        repeat (3) @(negedge clk_1khz);
        rst_n = 1'b1;
        disp_en = 1'b1;
        set_digits(5, 9, 9, 9);
        repeat (4 * SD * 3) @(negedge clk_1khz);

        // Inputs changing mid-frame, including invalid codes and disable.
        repeat (200) begin
            @(negedge clk_1khz);
            if ($urandom_range(0, 2) == 0) rand_digits();
            disp_en = ($urandom_range(0, 7) != 0);
        end

        // Leading-zero blanking.
        disp_en = 1'b1;
        set_digits(0, 7, 3, 1);
        repeat (4 * SD * 3) @(negedge clk_1khz);

        // Overflow blink, then steady again.
        set_digits(1, 2, 3, 4);
        time_out = 1'b1;
        repeat (60) @(negedge clk_1khz);
        time_out = 1'b0;
        repeat (30) @(negedge clk_1khz);

        // Error glyph and disable.
        set_digits(2, 12, 4, 5);
        repeat (4 * SD * 2) @(negedge clk_1khz);
        disp_en = 1'b0;
        repeat (5) @(negedge clk_1khz);
        disp_en = 1'b1;
        repeat (10) @(negedge clk_1khz);

        // Reset pulsed mid-frame.
        @(posedge clk_1khz);
        #2;
        rst_n = 1'b0;
        @(posedge clk_1khz);
        @(negedge clk_1khz);
        rst_n = 1'b1;
        repeat (4 * SD * 2) @(negedge clk_1khz);

        // Fully random mix including overflow toggling.
        repeat (400) begin
            @(negedge clk_1khz);
            if ($urandom_range(0, 3) == 0) rand_digits();
            disp_en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 24) == 0) time_out = ~time_out;
        end

        repeat (3) @(negedge clk_1khz);
        #2;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
